stats_ctrl: RTL and testbench
=============================

STATS_CTRL -- requirements
Module: stats_ctrl

Interface
REQ-001 SHALL have parameter CW, default 11, counter and data width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op  input  6  opcode of the instruction retiring this cycle.
REQ-005 SHALL have port instr_valid  input  1  op is a real retiring instruction this cycle.
REQ-006 SHALL have port start  input  1  one-cycle command to enable counting.
REQ-007 SHALL have port stop  input  1  one-cycle command to disable counting.
REQ-008 SHALL have port clear  input  1  one-cycle command to zero all live counters.
REQ-009 SHALL have port dump_req  input  1  one-cycle command to snapshot the counters and stream them out.
REQ-010 SHALL have port out_data  output  CW  word currently offered on the stream.
REQ-011 SHALL have port out_idx  output  2  word index: 0=cnt_clk, 1=r, 2=i, 3=j.
REQ-012 SHALL have port out_valid  output  1  out_data/out_idx valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-014 SHALL have port running  output  1  counting enabled.
REQ-015 SHALL have port busy  output  1  dump in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse after word 3 is accepted.

Function
REQ-017 SHALL keep four live CW-bit counters: cnt_clk, r, i, j.
REQ-018 SHALL classify op as follows: 6'b000000 -> R; 6'b000010 or 6'b000011 -> J; any other value -> I.
REQ-019 SHALL, while running=1, increment cnt_clk every cycle, and increment the class counter of op when instr_valid=1.
REQ-020 SHALL saturate every counter at 2^CW-1; a saturated counter SHALL never wrap to 0.
REQ-021 SHALL use a run flag independent of the dump FSM; counting continues during a dump.
REQ-022 SHALL apply commands with priority clear > stop > start; the command takes effect on the next edge.
REQ-023 SHALL zero all four live counters on clear and take no increments in that cycle; clear SHALL NOT change running.
REQ-024 SHALL, when stop and start are asserted together, clear running.
REQ-025 SHALL implement a dump FSM with states IDLE and SEND; idx is a 2-bit word pointer.
REQ-026 SHALL, in IDLE with dump_req=1, copy the four live counters into shadow registers (pre-increment and pre-clear values of that cycle), set idx=0, and go to SEND.
REQ-027 SHALL, in SEND, drive out_valid=1, out_idx=idx, and out_data=shadow[idx].
REQ-028 SHALL hold out_data and out_idx stable while out_valid=1 and out_ready=0.
REQ-029 SHALL, on out_valid&&out_ready, advance idx; when idx=3 is accepted, go to IDLE and pulse done for one cycle.
REQ-030 SHALL ignore dump_req while in SEND; shadow registers SHALL be unaffected by clear or counting during SEND.
REQ-031 SHALL have a minimum dump latency of dump_req edge -> first out_valid = 1 cycle, and back-to-back words at 1 word/cycle when out_ready=1.
REQ-032 SHALL drive busy=1 exactly when in SEND.

Reset
REQ-033 SHALL, on reset=1 at a rising edge, set counters and shadows to 0, running=0, FSM=IDLE, idx=0, out_valid=0, busy=0, done=0, out_data=0, out_idx=0.
REQ-034 SHALL abort any dump in progress on reset mid-SEND with no done pulse, and give reset priority over all commands.

Verification
REQ-035 SHALL verify counting: reset, start, then retire ops 000000 x2, 001000, 001101, 001100, 000010, 000011, 001000, 000000 on consecutive cycles with instr_valid=1, then stop -> r=3, i=4, j=2, cnt_clk=9 on the following cycle.
REQ-036 SHALL verify the dump handshake: dump_req with out_ready=1 -> words (0,9),(1,3),(2,4),(3,2) on 4 consecutive cycles, done pulse once, busy low afterwards.
REQ-037 SHALL verify backpressure: out_ready=0 for 3 cycles during word 1 -> out_data=3 and out_idx=1 held stable, with no skipped or duplicated word.
REQ-038 SHALL verify command collisions: clear with dump_req in the same cycle, live r=3 -> streamed r=3 and live r=0 next cycle; stop+start together -> running=0.
REQ-039 SHALL verify saturation: CW=3, running with 10 R instructions -> r=7 held and cnt_clk=7.
REQ-040 SHALL verify reset mid-dump: reset during word 2 -> out_valid=0 next cycle, no done, all counters 0, running=0.

Source files
------------

// File: rtl/stats_ctrl.sv
// Instruction-class statistics counters with a snapshot-and-stream dump port.
// Counting (run flag) and dumping (IDLE/SEND FSM) are independent so counting continues during a dump.
module stats_ctrl #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    op,
    input  logic          instr_valid,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    input  logic          dump_req,
    output logic [CW-1:0] out_data,
    output logic [1:0]    out_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          running,
    output logic          busy,
    output logic          done
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    localparam logic [CW-1:0] MAX_CNT = '1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_capture;
    logic          r_run;
    logic [CW-1:0] r_live   [4];
    logic [CW-1:0] r_shadow [4];
    logic          w_is_r;
    logic          w_is_j;
    logic [3:0]    w_inc;

    // Word order on the stream and in both arrays: 0=cnt_clk, 1=r, 2=i, 3=j.
    assign w_is_r   = (op == 6'b000000);
    assign w_is_j   = (op == 6'b000010) || (op == 6'b000011);
    assign w_inc[0] = r_run;
    assign w_inc[1] = r_run && instr_valid && w_is_r;
    assign w_inc[2] = r_run && instr_valid && !w_is_r && !w_is_j;
    assign w_inc[3] = r_run && instr_valid && w_is_j;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_done  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_live[k]   <= '0;
                r_shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (clear)
                    r_live[k] <= '0;
                else if (w_inc[k] && (r_live[k] != MAX_CNT))
                    r_live[k] <= r_live[k] + 1'b1;
            end
            if (!clear) begin
                if (stop)
                    r_run <= 1'b0;
                else if (start)
                    r_run <= 1'b1;
            end
            // Shadows take the values live in the dump_req cycle, before that cycle's clear/increment.
            if (w_capture) begin
                for (int k = 0; k < 4; k++)
                    r_shadow[k] <= r_live[k];
            end
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Stream handshake: a word transfers on a rising edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_idx/out_data hold, and out_valid never drops early.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dump_req) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign out_valid = (r_state == ST_SEND);
    assign busy      = (r_state == ST_SEND);
    assign out_idx   = out_valid ? r_idx : 2'd0;
    assign out_data  = out_valid ? r_shadow[r_idx] : '0;
    assign running   = r_run;
    assign done      = r_done;

endmodule

// File: tb/tb_stats_ctrl.sv
// Self-checking bench for stats_ctrl: directed scenarios plus a randomized run scored
// against an integer reference model of the counting and dump rules.
module tb_stats_ctrl;

    localparam int CW   = 11;
    localparam int W    = CW + 2;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    op;
    logic          instr_valid, start, stop, clear, dump_req, out_ready;
    logic [CW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_valid, running, busy, done;

    logic [5:0]    s_op;
    logic          s_valid, s_start, s_stop, s_clear, s_dump, s_ready;
    logic [2:0]    s_data;
    logic [1:0]    s_idx;
    logic          s_out_valid, s_running, s_busy, s_done;

    always #5 clk = ~clk;

    stats_ctrl #(.CW(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .instr_valid(instr_valid),
        .start(start), .stop(stop), .clear(clear), .dump_req(dump_req),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .running(running), .busy(busy), .done(done)
    );

    stats_ctrl #(.CW(3)) u_sat (
        .clk(clk), .reset(reset), .op(s_op), .instr_valid(s_valid),
        .start(s_start), .stop(s_stop), .clear(s_clear), .dump_req(s_dump),
        .out_data(s_data), .out_idx(s_idx), .out_valid(s_out_valid),
        .out_ready(s_ready), .running(s_running), .busy(s_busy), .done(s_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    // Reference model: plain integer counts and a words-remaining count for the dump.
    int m_clk, m_r, m_i, m_j;
    bit m_run;
    int m_left;
    bit m_done;

    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back({out_idx, out_data});
    end

    function automatic int sat_inc(input int v);
        return (v < MAXV) ? v + 1 : v;
    endfunction

    task automatic model_zero();
        m_clk = 0; m_r = 0; m_i = 0; m_j = 0;
        m_run = 0; m_left = 0; m_done = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic cyc(input logic [5:0] t_op, input logic t_v, input logic t_start,
                       input logic t_stop, input logic t_clear, input logic t_dump,
                       input logic t_ready);
        bit sending;
        op = t_op; instr_valid = t_v; start = t_start; stop = t_stop;
        clear = t_clear; dump_req = t_dump; out_ready = t_ready;
        sending = (m_left > 0);
        m_done  = sending && t_ready && (m_left == 1);
        if (sending && t_ready) m_left--;
        if (!sending && t_dump) begin
            exp_q.push_back({2'd0, CW'(m_clk)});
            exp_q.push_back({2'd1, CW'(m_r)});
            exp_q.push_back({2'd2, CW'(m_i)});
            exp_q.push_back({2'd3, CW'(m_j)});
            m_left = 4;
        end
        if (t_clear) begin
            m_clk = 0; m_r = 0; m_i = 0; m_j = 0;
        end else if (m_run) begin
            m_clk = sat_inc(m_clk);
            if (t_v) begin
                if (t_op == 6'd0) m_r = sat_inc(m_r);
                else if (t_op == 6'd2 || t_op == 6'd3) m_j = sat_inc(m_j);
                else m_i = sat_inc(m_i);
            end
        end
        if (!t_clear) begin
            if (t_stop) m_run = 0;
            else if (t_start) m_run = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic t_ready);
        cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t_ready);
    endtask

    task automatic do_reset();
        op = 6'd0; instr_valid = 0; start = 0; stop = 0; clear = 0; dump_req = 0; out_ready = 0;
        s_op = 6'd0; s_valid = 0; s_start = 0; s_stop = 0; s_clear = 0; s_dump = 0; s_ready = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_zero();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL reset_running got=%b exp=0", running); end
        n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        n_checks++; if (out_idx !== 2'd0) begin n_errors++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
    endtask

    task automatic test_counting();
        logic [5:0] ops [9];
        ops = '{6'b000000, 6'b000000, 6'b001000, 6'b001101, 6'b001100,
                6'b000010, 6'b000011, 6'b001000, 6'b000000};
        cyc(6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (running !== 1'b1) begin n_errors++; $display("FAIL count_start_running got=%b exp=1", running); end
        for (int k = 0; k < 9; k++)
            cyc(ops[k], 1'b1, 1'b0, (k == 8), 1'b0, 1'b0, 1'b0);
        n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL count_stop_running got=%b exp=0", running); end
    endtask

    task automatic test_dump();
        int exp_w [4];
        exp_w = '{9, 3, 4, 2};
        got_q.delete(); exp_q.delete();
        cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL dump_valid w%0d got=%b exp=1", k, out_valid); end
            n_checks++; if (out_idx !== 2'(k)) begin n_errors++; $display("FAIL dump_idx w%0d got=%0d exp=%0d", k, out_idx, k); end
            n_checks++; if (out_data !== CW'(exp_w[k])) begin n_errors++; $display("FAIL dump_data w%0d got=%0d exp=%0d", k, out_data, exp_w[k]); end
            n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL dump_busy_done w%0d got=%b%b exp=10", k, busy, done); end
            idle(1'b1);
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL dump_done_pulse got=%b exp=1", done); end
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL dump_end_idle busy=%b valid=%b exp=00", busy, out_valid); end
        idle(1'b1);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL dump_done_once got=%b exp=0", done); end
        n_checks++; if (got_q.size() != 4) begin n_errors++; $display("FAIL dump_word_count got=%0d exp=4", got_q.size()); end
    endtask

    task automatic test_backpressure();
        int exp_w [4];
        exp_w = '{9, 3, 4, 2};
        got_q.delete(); exp_q.delete();
        cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== CW'(3)) begin
                n_errors++;
                $display("FAIL bp_hold c%0d got valid=%b idx=%0d data=%0d exp valid=1 idx=1 data=3", k, out_valid, out_idx, out_data);
            end
        end
        for (int k = 0; k < 3; k++) idle(1'b1);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (got_q.size() != 4) begin
            n_errors++; $display("FAIL bp_word_count got=%0d exp=4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got_q[k] !== {2'(k), CW'(exp_w[k])}) begin
                    n_errors++; $display("FAIL bp_word%0d got=%h exp=%h", k, got_q[k], {2'(k), CW'(exp_w[k])});
                end
            end
        end
    endtask

    task automatic test_collisions();
        got_q.delete(); exp_q.delete();
        cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);
        n_checks++;
        if (got_q.size() != 4) begin
            n_errors++; $display("FAIL coll_word_count got=%0d exp=4", got_q.size());
        end else if (got_q[1] !== {2'd1, CW'(3)}) begin
            n_errors++; $display("FAIL coll_streamed_r got=%h exp=%h", got_q[1], {2'd1, CW'(3)});
        end
        got_q.delete(); exp_q.delete();
        cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);
        n_checks++;
        if (got_q.size() != 4) begin
            n_errors++; $display("FAIL coll_clear_count got=%0d exp=4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got_q[k] !== {2'(k), CW'(0)}) begin
                    n_errors++; $display("FAIL coll_cleared_word%0d got=%h exp=%h", k, got_q[k], {2'(k), CW'(0)});
                end
            end
        end
        cyc(6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (running !== 1'b1) begin n_errors++; $display("FAIL coll_start got=%b exp=1", running); end
        cyc(6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL coll_stop_start got=%b exp=0", running); end
    endtask

    task automatic test_saturation();
        int exp_w [4];
        exp_w = '{7, 7, 0, 0};
        do_reset();
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            s_op = 6'd0; s_valid = 1'b1; s_stop = (k == 9);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_stop = 1'b0; s_dump = 1'b1; s_ready = 1'b1;
        @(posedge clk); #1;
        s_dump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (s_out_valid !== 1'b1 || s_idx !== 2'(k) || s_data !== 3'(exp_w[k])) begin
                n_errors++;
                $display("FAIL sat_word%0d got valid=%b idx=%0d data=%0d exp valid=1 idx=%0d data=%0d", k, s_out_valid, s_idx, s_data, k, exp_w[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++; if (s_done !== 1'b1) begin n_errors++; $display("FAIL sat_done got=%b exp=1", s_done); end
        s_ready = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        int n_done;
        do_reset();
        cyc(6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(6'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 2'd2) begin n_errors++; $display("FAIL rmd_at_word2 got valid=%b idx=%0d exp valid=1 idx=2", out_valid, out_idx); end
        start = 1'b1; dump_req = 1'b1; out_ready = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; dump_req = 1'b0;
        model_zero();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rmd_valid_busy got=%b%b exp=00", out_valid, busy); end
        n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL rmd_running got=%b exp=0", running); end
        n_checks++; if (out_data !== '0 || out_idx !== 2'd0) begin n_errors++; $display("FAIL rmd_outputs got data=%0d idx=%0d exp 0 0", out_data, out_idx); end
        n_done = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            if (done === 1'b1) n_done++;
        end
        n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL rmd_no_done got=%0d exp=0", n_done); end
        cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);
        n_checks++;
        if (got_q.size() != 4) begin
            n_errors++; $display("FAIL rmd_word_count got=%0d exp=4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got_q[k] !== {2'(k), CW'(0)}) begin
                    n_errors++; $display("FAIL rmd_zero_word%0d got=%h exp=%h", k, got_q[k], {2'(k), CW'(0)});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] r_op;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0: r_op = 6'd0;
                1: r_op = 6'd2;
                2: r_op = 6'd3;
                default: r_op = 6'($urandom_range(0, 63));
            endcase
            cyc(r_op, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
            n_checks++; if (out_valid !== (m_left > 0)) begin n_errors++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, out_valid, (m_left > 0)); end
            n_checks++; if (busy !== (m_left > 0)) begin n_errors++; $display("FAIL rnd_busy c%0d got=%b exp=%b", c, busy, (m_left > 0)); end
            n_checks++; if (done !== m_done) begin n_errors++; $display("FAIL rnd_done c%0d got=%b exp=%b", c, done, m_done); end
            n_checks++; if (running !== m_run) begin n_errors++; $display("FAIL rnd_running c%0d got=%b exp=%b", c, running, m_run); end
        end
        for (int k = 0; k < 20 && m_left > 0; k++) idle(1'b1);
        n_checks++; if (m_left != 0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rnd_drain_timeout left=%0d valid=%b exp 0 0", m_left, out_valid); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL rnd_word_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_errors++; $display("FAIL rnd_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_dump();
        test_backpressure();
        test_collisions();
        test_saturation();
        test_reset_mid_dump();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
